// File: rtl/pheap_arbiter.sv
// ---------------------------------------------------------------------------
// pheap_arbiter
//
// Shares one pheap priority queue among NUM_REQ simulation cores. Enqueue and
// dequeue requests are arbitrated round-robin. At most one heap command is
// issued every two cycles (an IDLE/GAP pair). A dequeue returns the current
// heap minimum to the granted core.
//
// Configuration macro:
//   PHEAP_ARB_DEQ_PRIO_EN  when defined, any eligible dequeue beats every
//                          eligible enqueue. Round-robin runs within the
//                          winning op class, and the pointer is shared.
//                          When undefined, one round-robin covers all
//                          eligible cores regardless of op.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_enq/deq     per-core level requests, held until gnt
//   req_data        core i event in [i*WIDTH +: WIDTH]
//   gnt             one-hot grant pulse (1 cycle)
//   rsp_vld/id/data dequeue response; rsp_data holds until the next dequeue
//   heap_enq/deq    command pulses to pheap
//   heap_inp_data   event to pheap
//   heap_out_data   current pheap minimum
//   heap_full/empty/ready  pheap status
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | sample requests, grant one eligible core and issue its heap command
// GAP   | all pulses low; heap settles and the granted core drops its request
// ---------------------------------------------------------------------------
module pheap_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_enq,
   input  logic [NUM_REQ-1:0]         req_deq,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       rsp_vld,
   output logic [ID_W-1:0]            rsp_id,
   output logic [WIDTH-1:0]           rsp_data,
   output logic                       heap_enq,
   output logic                       heap_deq,
   output logic [WIDTH-1:0]           heap_inp_data,
   input  logic [WIDTH-1:0]           heap_out_data,
   input  logic                       heap_full,
   input  logic                       heap_empty,
   input  logic                       heap_ready
);

   if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W < $clog2(NUM_REQ) || DEPTH < 1) begin : g_bad_params
      $error("pheap_arbiter: illegal parameter combination");
   end

   localparam logic       IDLE = 1'b0;
   localparam logic       GAP  = 1'b1;

   localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

   logic                   state;
   logic [ID_W-1:0]        ptr;

   logic                   enq_ok;
   logic                   deq_ok;
   logic [NUM_REQ-1:0]     enq_elig;
   logic [NUM_REQ-1:0]     deq_elig;
   logic [NUM_REQ-1:0]     cand;
   logic [2*NUM_REQ-1:0]   cand_x2;
   logic [NUM_REQ-1:0]     rot;
   logic                   found;
   logic [ID_W-1:0]        ofs;
   logic [ID_W:0]          sum;
   logic [ID_W-1:0]        win;
   logic [ID_W-1:0]        next_ptr;
   logic                   win_is_enq;
   logic [WIDTH-1:0]       win_data;

   // A core asking for both ops only competes with its enqueue; its dequeue
   // is masked even when the enqueue itself is blocked by a full heap.
   assign enq_ok   = !heap_full && heap_ready;
   assign deq_ok   = !heap_empty;
   assign enq_elig = req_enq & {NUM_REQ{enq_ok}};
   assign deq_elig = req_deq & ~req_enq & {NUM_REQ{deq_ok}};

`ifdef PHEAP_ARB_DEQ_PRIO_EN
   assign cand = (|deq_elig) ? deq_elig : enq_elig;
`else
   assign cand = enq_elig | deq_elig;
`endif

   // Rotate the candidate vector so the pointer position lands on bit 0;
   // the lowest set bit of the rotated vector is the round-robin winner.
   assign cand_x2 = {cand, cand};
   assign rot     = NUM_REQ'(cand_x2 >> ptr);

   always_comb begin
      found = 1'b0;
      ofs   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            ofs   = ID_W'(k);
         end
      end
   end

   assign sum      = {1'b0, ptr} + {1'b0, ofs};
   assign win      = (sum >= NUM_REQ_W) ? ID_W'(sum - NUM_REQ_W) : ID_W'(sum);
   assign next_ptr = (win == LAST_ID) ? '0 : win + 1'b1;

   always_comb begin
      win_is_enq = 1'b0;
      win_data   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win == ID_W'(k)) begin
            win_is_enq = enq_elig[k];
            win_data   = req_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= '0;
         gnt           <= '0;
         rsp_vld       <= 1'b0;
         rsp_id        <= '0;
         rsp_data      <= '0;
         heap_enq      <= 1'b0;
         heap_deq      <= 1'b0;
         heap_inp_data <= '0;
      end else begin
         gnt      <= '0;
         rsp_vld  <= 1'b0;
         heap_enq <= 1'b0;
         heap_deq <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt           <= NUM_REQ'(1) << win;
                  heap_enq      <= win_is_enq;
                  heap_deq      <= !win_is_enq;
                  heap_inp_data <= win_data;
                  ptr           <= next_ptr;
                  state         <= GAP;
                  if (!win_is_enq) begin
                     rsp_vld  <= 1'b1;
                     rsp_id   <= win;
                     rsp_data <= heap_out_data;
                  end
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pheap_arbiter.sv
module tb_pheap_arbiter;
   localparam int N   = 4;
   localparam int IW  = 2;
   localparam int W   = 32;
   localparam int D   = 6;
   localparam int CAP = 63;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_enq = '0;
   logic [N-1:0]     req_deq = '0;
   logic [N*W-1:0]   req_data = '0;
   logic [N-1:0]     gnt;
   logic             rsp_vld;
   logic [IW-1:0]    rsp_id;
   logic [W-1:0]     rsp_data;
   logic             heap_enq;
   logic             heap_deq;
   logic [W-1:0]     heap_inp_data;
   logic [W-1:0]     heap_out_data = '0;
   logic             heap_full = 1'b0;
   logic             heap_empty = 1'b1;
   logic             heap_ready = 1'b1;

   pheap_arbiter #(.NUM_REQ(N), .ID_W(IW), .WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .req_enq(req_enq), .req_deq(req_deq), .req_data(req_data),
      .gnt(gnt), .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .heap_enq(heap_enq), .heap_deq(heap_deq), .heap_inp_data(heap_inp_data),
      .heap_out_data(heap_out_data), .heap_full(heap_full),
      .heap_empty(heap_empty), .heap_ready(heap_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      bit         deq;
      logic [W-1:0] data;
      int         gap;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         e;
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           last_gnt_cyc = -100;
   bit           prev_enq = 1'b0;
   logic [W-1:0] hq[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Behavioural pheap: sorted queue, commands committed on the falling edge
   // so the arbiter sees updated status at the next IDLE decision.
   always @(negedge clk) begin
      if (rst) begin
         hq.delete();
      end else begin
         if (heap_enq) begin
            hq.push_back(heap_inp_data);
            hq.sort();
         end
         if (heap_deq && hq.size() > 0) void'(hq.pop_front());
      end
      heap_empty    = (hq.size() == 0);
      heap_full     = (hq.size() >= CAP);
      heap_out_data = (hq.size() == 0) ? '0 : hq[0];
      heap_ready    = 1'b1;
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      cyc++;
      if (heap_enq && heap_deq) begin
         n_cmp++; n_err++;
         $display("FAIL enq_deq_overlap: got both high expected exclusive");
      end
      if (heap_enq && prev_enq) begin
         n_cmp++; n_err++;
         $display("FAIL enq_back_to_back: got heap_enq in consecutive cycles expected gap");
      end
      prev_enq = heap_enq;
      if (rst) begin
         last_gnt_cyc = -100;
      end else if (gnt != '0) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_gnt: got gnt=%b expected none", gnt);
         end else begin
            e = exp_q.pop_front();
            check("gnt", 64'(gnt), 64'(1) << e.id);
            check("op_enq_deq_vld", 64'({heap_enq, heap_deq, rsp_vld}), e.deq ? 64'h3 : 64'h4);
            if (e.deq) begin
               check("rsp_id", 64'(rsp_id), 64'(e.id));
               check("rsp_data", 64'(rsp_data), 64'(e.data));
            end else begin
               check("inp_data", 64'(heap_inp_data), 64'(e.data));
            end
            if (e.gap > 0) check("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'(e.gap));
         end
         last_gnt_cyc = cyc;
      end
   end

   task automatic expect_gnt(int id, bit deq, logic [W-1:0] data, int gap);
      exp_t t;
      t.id = id; t.deq = deq; t.data = data; t.gap = gap;
      exp_q.push_back(t);
   endtask

   task automatic set_req(int id, bit enq, bit deq, logic [W-1:0] d);
      req_enq[id] = enq;
      req_deq[id] = deq;
      req_data[id*W +: W] = d;
   endtask

   task automatic chk_zero(string name);
      check({name, "_ctl"}, 64'({gnt, rsp_vld, rsp_id, heap_enq, heap_deq}), 64'h0);
      check({name, "_rsp_data"}, 64'(rsp_data), 64'h0);
      check({name, "_inp_data"}, 64'(heap_inp_data), 64'h0);
   endtask

   task automatic do_reset(bit chk);
      req_enq = '0;
      req_deq = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      if (chk) chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Wait for n grants; a granted core drops its request unless hold is set.
   task automatic run(int n, bit hold, int budget);
      int got = 0;
      int t = 0;
      while (got < n && t < budget) begin
         @(negedge clk);
         t++;
         if (gnt != '0) begin
            got++;
            if (!hold) begin
               for (int k = 0; k < N; k++) begin
                  if (gnt[k]) begin
                     req_enq[k] = 1'b0;
                     req_deq[k] = 1'b0;
                  end
               end
            end
         end
      end
      if (hold) begin
         req_enq = '0;
         req_deq = '0;
      end
      if (got < n) begin
         n_cmp++; n_err++;
         $display("FAIL grant_timeout: got %0d grants expected %0d", got, n);
      end
   endtask

   task automatic drained(string name);
      repeat (3) @(negedge clk);
      check(name, 64'(exp_q.size()), 64'h0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // 0/1: reset state, two enqueues in rr order, dequeue of the minimum
      do_reset(1'b1);
      set_req(0, 1'b1, 1'b0, 32'h30);
      set_req(1, 1'b1, 1'b0, 32'h10);
      expect_gnt(0, 1'b0, 32'h30, 0);
      expect_gnt(1, 1'b0, 32'h10, 2);
      run(2, 1'b0, 20);
      set_req(2, 1'b0, 1'b1, 32'h0);
      expect_gnt(2, 1'b1, 32'h10, 0);
      run(1, 1'b0, 20);
      drained("t1_drained");

      // 2: all cores hold enqueue continuously
      do_reset(1'b0);
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'h40 + i);
      expect_gnt(0, 1'b0, 32'h40, 0);
      expect_gnt(1, 1'b0, 32'h41, 2);
      expect_gnt(2, 1'b0, 32'h42, 2);
      expect_gnt(3, 1'b0, 32'h43, 2);
      expect_gnt(0, 1'b0, 32'h40, 2);
      run(5, 1'b1, 40);
      drained("t2_drained");

      // 3: dequeue on an empty heap stalls until an enqueue lands
      do_reset(1'b0);
      set_req(3, 1'b0, 1'b1, 32'h0);
      repeat (10) begin
         @(negedge clk);
         check("empty_stall_gnt", 64'(gnt), 64'h0);
      end
      set_req(0, 1'b1, 1'b0, 32'h5);
      expect_gnt(0, 1'b0, 32'h5, 0);
      expect_gnt(3, 1'b1, 32'h5, 2);
      run(2, 1'b0, 20);
      drained("t3_drained");

      // 4: full heap; enqueue stalls alone, dequeue is served first
      do_reset(1'b0);
      for (int i = 0; i < CAP; i++) hq.push_back(32'h100 + i);
      @(negedge clk);
      set_req(1, 1'b1, 1'b0, 32'h7);
      repeat (8) begin
         @(negedge clk);
         check("full_stall_gnt", 64'(gnt), 64'h0);
      end
      set_req(2, 1'b0, 1'b1, 32'h0);
      expect_gnt(2, 1'b1, 32'h100, 0);
      expect_gnt(1, 1'b0, 32'h7, 2);
      run(2, 1'b0, 20);
      drained("t4_drained");
      check("elem_cnt", 64'(hq.size()), 64'(CAP));

      // 5: simultaneous enq (core0) and deq (core1) with p=0
      do_reset(1'b0);
      hq.push_back(32'h11);
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 32'h20);
      set_req(1, 1'b0, 1'b1, 32'h0);
`ifdef PHEAP_ARB_DEQ_PRIO_EN
      expect_gnt(1, 1'b1, 32'h11, 0);
      expect_gnt(0, 1'b0, 32'h20, 2);
`else
      expect_gnt(0, 1'b0, 32'h20, 0);
      expect_gnt(1, 1'b1, 32'h11, 2);
`endif
      run(2, 1'b0, 20);
      // a core raising both ops only gets its enqueue
      set_req(2, 1'b1, 1'b1, 32'h22);
      expect_gnt(2, 1'b0, 32'h22, 0);
      run(1, 1'b0, 20);
      drained("t5_drained");

      // 6: reset asserted in the grant cycle
      do_reset(1'b0);
      set_req(0, 1'b1, 1'b0, 32'h33);
      expect_gnt(0, 1'b0, 32'h33, 0);
      run(1, 1'b0, 20);
      #1 rst = 1'b1;
      @(negedge clk);
      chk_zero("rst_in_gnt");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 32'h9);
      set_req(1, 1'b1, 1'b0, 32'h99);
      expect_gnt(0, 1'b0, 32'h9, 0);
      expect_gnt(1, 1'b0, 32'h99, 2);
      run(2, 1'b0, 20);
      set_req(2, 1'b0, 1'b1, 32'h0);
      expect_gnt(2, 1'b1, 32'h9, 0);
      run(1, 1'b0, 20);
      drained("t6_drained");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
